// File: rtl/seg7_scan_mux_pkg.sv
// Shared seven-segment display definitions: digit codes, active-low glyphs,
// scan FSM state type and the anode select helper.
package seg7_scan_mux_pkg;

  // Digit codes produced by the digit generators
  localparam logic [3:0] ZERO  = 4'd0;
  localparam logic [3:0] ONE   = 4'd1;
  localparam logic [3:0] TWO   = 4'd2;
  localparam logic [3:0] THREE = 4'd3;
  localparam logic [3:0] FOUR  = 4'd4;
  localparam logic [3:0] FIVE  = 4'd5;
  localparam logic [3:0] SIX   = 4'd6;
  localparam logic [3:0] SEVEN = 4'd7;
  localparam logic [3:0] EIGHT = 4'd8;
  localparam logic [3:0] NINE  = 4'd9;
  localparam logic [3:0] NULL  = 4'b1111;

  // Active-low segment patterns, bit order g f e d c b a
  localparam logic [6:0] SEG_0    = 7'h40;
  localparam logic [6:0] SEG_1    = 7'h79;
  localparam logic [6:0] SEG_2    = 7'h24;
  localparam logic [6:0] SEG_3    = 7'h30;
  localparam logic [6:0] SEG_4    = 7'h19;
  localparam logic [6:0] SEG_5    = 7'h12;
  localparam logic [6:0] SEG_6    = 7'h02;
  localparam logic [6:0] SEG_7    = 7'h78;
  localparam logic [6:0] SEG_8    = 7'h00;
  localparam logic [6:0] SEG_9    = 7'h10;
  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [6:0] SEG_DASH = 7'h3F;

  // Per-slot scan phase: anodes off (dead time) or anode lit
  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_ON    = 1'b1
  } slot_state_e;

  // One-hot-low anode pattern for a slot index
  function automatic logic [3:0] anode_sel(input logic [1:0] slot);
    logic [3:0] one_hot;
    one_hot = 4'b0001 << slot;
    return ~one_hot;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational digit-code to active-low segment decoder.
// Blank code turns everything off including dp; codes 10..14 show a dash.
module seg7_decode
  import seg7_scan_mux_pkg::*;
(
  input  logic [3:0] code,
  input  logic       dp,
  output logic [7:0] sseg
);

  logic [6:0] seg_s;
  logic       dp_n_s;

  // Map the digit code to its glyph and the dp bit to active-low
  always_comb begin
    seg_s  = SEG_DASH;
    dp_n_s = ~dp;
    case (code)
      ZERO:    seg_s = SEG_0;
      ONE:     seg_s = SEG_1;
      TWO:     seg_s = SEG_2;
      THREE:   seg_s = SEG_3;
      FOUR:    seg_s = SEG_4;
      FIVE:    seg_s = SEG_5;
      SIX:     seg_s = SEG_6;
      SEVEN:   seg_s = SEG_7;
      EIGHT:   seg_s = SEG_8;
      NINE:    seg_s = SEG_9;
      NULL: begin
        seg_s  = SEG_OFF;
        dp_n_s = 1'b1;
      end
      default: seg_s = SEG_DASH;
    endcase
  end

  assign sseg = {dp_n_s, seg_s};

endmodule

// File: rtl/seg7_scan_mux.sv
// Four-digit common-anode scan multiplexer. A slot counter walks the four
// anodes; each slot starts with a dead time (anodes off) while the segment
// lines already carry the new glyph. Digits are snapshotted once per frame.
// Anodes stay dark until the first snapshot after reset has been taken.
module seg7_scan_mux
  import seg7_scan_mux_pkg::*;
#(
  parameter int REFRESH_DIV  = 2**16 - 1,
  parameter int BLANK_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [3:0] dig_0,
  input  logic [3:0] dig_1,
  input  logic [3:0] dig_2,
  input  logic [3:0] dig_3,
  input  logic [3:0] dp_in,
  output logic [3:0] an,
  output logic [7:0] sseg,
  output logic       frame_tick
);

  localparam int               CNT_W     = $clog2(REFRESH_DIV + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] counter_r;
  logic [1:0]       slot_r;
  slot_state_e      state_r;
  logic [3:0][3:0]  frame_r;
  logic [3:0]       frame_dp_r;
  logic             primed_r;
  logic [3:0]       an_r;
  logic [7:0]       sseg_r;
  logic             frame_tick_r;

  logic             wrap_s;
  logic             snap_s;
  logic [CNT_W-1:0] counter_next_s;
  slot_state_e      state_next_s;
  logic [7:0]       glyph_s;

  // Counter wrap, snapshot strobe and next scan phase
  always_comb begin
    wrap_s         = 1'b0;
    snap_s         = 1'b0;
    counter_next_s = CNT_ZERO;
    state_next_s   = ST_BLANK;
    if (counter_r == CNT_MAX) begin
      wrap_s         = 1'b1;
      counter_next_s = CNT_ZERO;
    end else begin
      wrap_s         = 1'b0;
      counter_next_s = counter_r + CNT_ONE;
    end
    if (wrap_s && (slot_r == 2'd3)) begin
      snap_s = 1'b1;
    end else begin
      snap_s = 1'b0;
    end
    if (counter_next_s < CNT_BLANK) begin
      state_next_s = ST_BLANK;
    end else begin
      state_next_s = ST_ON;
    end
  end

  seg7_decode u_decode (
    .code (frame_r[slot_r]),
    .dp   (frame_dp_r[slot_r]),
    .sseg (glyph_s)
  );

  // Capture the generator digits once per frame, on the last cycle of slot 3
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_r    <= {4{NULL}};
      frame_dp_r <= 4'b0000;
      primed_r   <= 1'b0;
    end else if (snap_s) begin
      frame_r    <= {dig_3, dig_2, dig_1, dig_0};
      frame_dp_r <= dp_in;
      primed_r   <= 1'b1;
    end else begin
      frame_r    <= frame_r;
      frame_dp_r <= frame_dp_r;
      primed_r   <= primed_r;
    end
  end

  // Scan FSM: slot counter, slot index, phase and registered display outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      counter_r    <= CNT_ZERO;
      slot_r       <= 2'd0;
      state_r      <= ST_BLANK;
      an_r         <= 4'b1111;
      sseg_r       <= 8'hFF;
      frame_tick_r <= 1'b0;
    end else begin
      counter_r    <= counter_next_s;
      state_r      <= state_next_s;
      sseg_r       <= glyph_s;
      frame_tick_r <= snap_s;
      if (wrap_s) begin
        slot_r <= slot_r + 2'd1;
      end else begin
        slot_r <= slot_r;
      end
      case (state_r)
        ST_ON: begin
          if (enable && primed_r) begin
            an_r <= anode_sel(slot_r);
          end else begin
            an_r <= 4'b1111;
          end
        end
        ST_BLANK: an_r <= 4'b1111;
        default:  an_r <= 4'b1111;
      endcase
    end
  end

  assign an         = an_r;
  assign sseg       = sseg_r;
  assign frame_tick = frame_tick_r;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Scoreboard bench for seg7_scan_mux with an 8-cycle slot and 2-cycle dead time.
// Stimulus pushes per-cycle expected outputs; the monitor pops and compares.
module tb_seg7_scan_mux;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [3:0] dig_0, dig_1, dig_2, dig_3;
  logic [3:0] dp_in;
  logic [3:0] an;
  logic [7:0] sseg;
  logic       frame_tick;

  typedef struct {
    int         cyc;
    logic [3:0] an;
    logic [7:0] sseg;
    logic       tick;
    string      name;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   base   = 0;
  int   checks = 0;
  int   errors = 0;

  seg7_scan_mux #(
    .REFRESH_DIV  (7),
    .BLANK_CYCLES (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .dig_0      (dig_0),
    .dig_1      (dig_1),
    .dig_2      (dig_2),
    .dig_3      (dig_3),
    .dp_in      (dp_in),
    .an         (an),
    .sseg       (sseg),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs of frame k of the current reset epoch (32 output cycles).
  // j = state cycle within the frame; outputs appear one cycle later.
  // Output cycles whose state index j lies in [d0,d1] have enable low.
  task automatic push_frame(input int k, input logic [7:0] g0, input logic [7:0] g1,
                            input logic [7:0] g2, input logic [7:0] g3, input bit lit,
                            input int count, input int d0, input int d1, input string nm);
    logic [7:0] g [4];
    g[0] = g0; g[1] = g1; g[2] = g2; g[3] = g3;
    for (int j = 0; j < count; j++) begin
      int         slot;
      int         cnt;
      logic [3:0] one;
      exp_t       e;
      slot   = j / 8;
      cnt    = j % 8;
      one    = 4'b0001;
      e.cyc  = base + 32 * k + j + 1;
      e.an   = 4'b1111;
      if (lit && (cnt >= 2) && !((j >= d0) && (j <= d1))) e.an = ~(one << slot);
      e.sseg = g[slot];
      e.tick = (j == 31);
      e.name = nm;
      q.push_back(e);
    end
  endtask

  // Called at a negedge: reset is sampled on the next posedge (epoch cycle 0)
  task automatic apply_reset();
    exp_t e;
    reset  = 1'b1;
    base   = cyc + 1;
    e.cyc  = base;
    e.an   = 4'b1111;
    e.sseg = 8'hFF;
    e.tick = 1'b0;
    e.name = "reset_values";
    q.push_back(e);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Advance to the negedge of absolute cycle c
  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor: count cycles and compare against scoreboard entries due now
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      #1;
      while ((q.size() > 0) && (q[0].cyc <= cyc)) begin
        e = q.pop_front();
        if (e.cyc < cyc) begin
          checks = checks + 1;
          errors = errors + 1;
          $display("FAIL %s missed_cycle got=%0d required=%0d", e.name, cyc, e.cyc);
        end else begin
          checks = checks + 3;
          if (an !== e.an) begin
            errors = errors + 1;
            $display("FAIL %s an cycle %0d got=%b required=%b", e.name, cyc - base, an, e.an);
          end
          if (sseg !== e.sseg) begin
            errors = errors + 1;
            $display("FAIL %s sseg cycle %0d got=%h required=%h", e.name, cyc - base, sseg, e.sseg);
          end
          if (frame_tick !== e.tick) begin
            errors = errors + 1;
            $display("FAIL %s frame_tick cycle %0d got=%b required=%b", e.name, cyc - base, frame_tick, e.tick);
          end
        end
      end
    end
  end

  // Directed stimulus
  initial begin
    reset  = 1'b1;
    enable = 1'b1;
    dig_3  = 4'd1; dig_2 = 4'd2; dig_1 = 4'd3; dig_0 = 4'd4;
    dp_in  = 4'b0000;
    @(negedge clk);
    apply_reset();

    // Frame 0 dark, frame 1 shows 1 2 3 4
    push_frame(0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0, 32, -1, -1, "first_frame_dark");
    push_frame(1, 8'h99, 8'hB0, 8'hA4, 8'hF9, 1'b1, 32, -1, -1, "digits_1234");

    // Mid-frame change to all blank: shown only from frame 2
    wait_to(base + 40);
    dig_0 = 4'hF; dig_1 = 4'hF; dig_2 = 4'hF; dig_3 = 4'hF;
    push_frame(2, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b1, 32, -1, -1, "all_blank");

    // Dash with dp on digit 0, then 0 5 9
    wait_to(base + 70);
    dig_0 = 4'b1011; dp_in = 4'b0001; dig_1 = 4'd0; dig_2 = 4'd5; dig_3 = 4'd9;
    push_frame(3, 8'h3F, 8'hC0, 8'h92, 8'h90, 1'b1, 32, -1, -1, "dash_dp_059");

    // dig_2 5->6 mid frame 3; dig_1 changes on the snapshot cycle; dig_3 one later
    wait_to(base + 100);
    dig_2 = 4'd6;
    wait_to(base + 127);
    dig_1 = 4'd7;
    wait_to(base + 128);
    dig_3 = 4'd8;
    push_frame(4, 8'h3F, 8'hF8, 8'h82, 8'h90, 1'b1, 32, -1, -1, "snapshot_edge");

    // enable low for 10 cycles across the slot 0 -> slot 1 boundary
    push_frame(5, 8'h3F, 8'hF8, 8'h82, 8'h80, 1'b1, 32, 4, 13, "enable_gap");
    wait_to(base + 164);
    enable = 1'b0;
    wait_to(base + 174);
    enable = 1'b1;

    // Reset during slot 2 ON of frame 6
    push_frame(6, 8'h3F, 8'hF8, 8'h82, 8'h80, 1'b1, 20, -1, -1, "pre_reset");
    wait_to(base + 212);
    apply_reset();
    push_frame(0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0, 32, -1, -1, "post_reset_dark");
    push_frame(1, 8'h3F, 8'hF8, 8'h82, 8'h80, 1'b1, 32, -1, -1, "post_reset_lit");

    for (int i = 0; (i < 200) && (q.size() > 0); i++) @(negedge clk);
    if (q.size() != 0) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL scoreboard_drain pending=%0d required=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
